// File: rtl/act_reader_pkg.sv
// Shared constants, FSM state type and the group-A address/bank mapping
// used by the activation reader (and by writer-side checkers).
package act_reader_pkg;

    localparam int unsigned CH_NUM       = 4;
    localparam int unsigned ACT_PER_ADDR = 4;
    localparam int unsigned BW_PER_ACT   = 8;
    localparam int unsigned BEAT_W       = ACT_PER_ADDR * BW_PER_ACT;
    localparam int unsigned WORD_W       = CH_NUM * BEAT_W;

    localparam int unsigned MAP_DIM   = 5;
    localparam int unsigned NUM_GQ    = 4;
    localparam int unsigned NUM_BEATS = 400;
    localparam int unsigned NUM_READS = 100;

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned PIX_W  = 8;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StDrain,
        StDone
    } state_e;

    // Word tag travelling with each read: group quad, row, column.
    typedef struct packed {
        logic [1:0] gq;
        logic [2:0] row;
        logic [2:0] col;
    } pix_t;

    localparam pix_t LAST_PIX = '{gq: 2'd3, row: 3'd4, col: 3'd4};

    // Bank holding pixel (row, col): even/odd row and column split.
    function automatic logic [1:0] map_bank(input logic [2:0] row, input logic [2:0] col);
        return {row[0], col[0]};
    endfunction

    // Word address inside the bank: 18*gq[1] + 3*gq[0] + 6*row[2:1] + col[2:1].
    function automatic logic [ADDR_W-1:0] map_addr(input logic [1:0] gq,
                                                   input logic [2:0] row,
                                                   input logic [2:0] col);
        logic [ADDR_W-1:0] a;
        a = (gq[1] ? 6'd18 : 6'd0)
          + (gq[0] ? 6'd3 : 6'd0)
          + ADDR_W'(row[2:1]) * 6'd6
          + ADDR_W'(col[2:1]);
        return a;
    endfunction

endpackage

// File: rtl/act_reader_wbuf.sv
// Two-entry word buffer for the activation reader, built as a skid buffer:
// the head entry feeds the output lane by lane, the skid entry catches the
// next word while the head is still draining.
module act_reader_wbuf
    import act_reader_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                wr_en_i,
    input  logic [WORD_W-1:0]   wr_word_i,
    input  logic [PIX_W-1:0]    wr_pix_i,
    input  logic                rd_ready_i,
    output logic                rd_valid_o,
    output logic [BEAT_W-1:0]   rd_data_o,
    output logic [PIX_W-1:0]    rd_pix_o,
    output logic [1:0]          rd_lane_o,
    output logic                rd_pop_o,
    output logic [1:0]          count_o
);

    logic [WORD_W-1:0] head_word_q, head_word_d;
    logic [WORD_W-1:0] skid_word_q, skid_word_d;
    logic [PIX_W-1:0]  head_pix_q, head_pix_d;
    logic [PIX_W-1:0]  skid_pix_q, skid_pix_d;
    logic              head_vld_q, head_vld_d;
    logic              skid_vld_q, skid_vld_d;
    logic [1:0]        lane_q, lane_d;
    logic              accept;
    logic              pop;

    assign accept = head_vld_q & rd_ready_i;
    assign pop    = accept & (lane_q == 2'd3);

    // Next-state of the two entries and the lane pointer of the head word.
    always_comb begin
        head_word_d = head_word_q;
        skid_word_d = skid_word_q;
        head_pix_d  = head_pix_q;
        skid_pix_d  = skid_pix_q;
        head_vld_d  = head_vld_q;
        skid_vld_d  = skid_vld_q;
        lane_d      = lane_q;

        // Lane pointer wraps to 0 after lane 3.
        if (accept) begin
            lane_d = lane_q + 2'd1;
        end

        if (pop) begin
            if (skid_vld_q) begin
                head_word_d = skid_word_q;
                head_pix_d  = skid_pix_q;
                head_vld_d  = 1'b1;
                skid_vld_d  = wr_en_i;
                if (wr_en_i) begin
                    skid_word_d = wr_word_i;
                    skid_pix_d  = wr_pix_i;
                end
            end else begin
                head_vld_d = wr_en_i;
                if (wr_en_i) begin
                    head_word_d = wr_word_i;
                    head_pix_d  = wr_pix_i;
                end
            end
        end else if (!head_vld_q) begin
            head_vld_d = wr_en_i;
            if (wr_en_i) begin
                head_word_d = wr_word_i;
                head_pix_d  = wr_pix_i;
            end
        end else if (wr_en_i) begin
            // Upstream credit check guarantees the skid slot is free here.
            skid_vld_d  = 1'b1;
            skid_word_d = wr_word_i;
            skid_pix_d  = wr_pix_i;
        end
    end

    // Buffer state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_word_q <= '0;
            skid_word_q <= '0;
            head_pix_q  <= '0;
            skid_pix_q  <= '0;
            head_vld_q  <= 1'b0;
            skid_vld_q  <= 1'b0;
            lane_q      <= 2'd0;
        end else begin
            head_word_q <= head_word_d;
            skid_word_q <= skid_word_d;
            head_pix_q  <= head_pix_d;
            skid_pix_q  <= skid_pix_d;
            head_vld_q  <= head_vld_d;
            skid_vld_q  <= skid_vld_d;
            lane_q      <= lane_d;
        end
    end

    // Lane select: lane 0 is the top 32 bits of the word.
    always_comb begin
        rd_data_o = '0;
        for (int l = 0; l < int'(CH_NUM); l++) begin
            if (lane_q == l[1:0]) begin
                rd_data_o = head_word_q[WORD_W-1-l*BEAT_W -: BEAT_W];
            end
        end
    end

    assign rd_valid_o = head_vld_q;
    assign rd_pix_o   = head_pix_q;
    assign rd_lane_o  = lane_q;
    assign rd_pop_o   = pop;
    assign count_o    = {1'b0, head_vld_q} + {1'b0, skid_vld_q};

endmodule

// File: rtl/act_a_reader.sv
// Read-back engine for SRAM group A (5x5x64 map, four banks). Scans the map,
// issues one read per 128-bit word, and streams four 32-bit beats per word.
// Optional build macro ACT_READER_PERF_EN adds the stall_cnt_o counter.
module act_a_reader
    import act_reader_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [ADDR_W-1:0]   sram_raddr_a0_o,
    output logic [ADDR_W-1:0]   sram_raddr_a1_o,
    output logic [ADDR_W-1:0]   sram_raddr_a2_o,
    output logic [ADDR_W-1:0]   sram_raddr_a3_o,
    input  logic [WORD_W-1:0]   sram_rdata_a0_i,
    input  logic [WORD_W-1:0]   sram_rdata_a1_i,
    input  logic [WORD_W-1:0]   sram_rdata_a2_i,
    input  logic [WORD_W-1:0]   sram_rdata_a3_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [BEAT_W-1:0]   out_data_o,
    output logic [3:0]          out_grp_o,
    output logic [2:0]          out_row_o,
    output logic [2:0]          out_col_o,
    output logic                out_last_o
`ifdef ACT_READER_PERF_EN
    ,
    output logic [15:0]         stall_cnt_o
`endif
);

    state_e            state_q, state_d;
    logic [1:0]        gq_q, gq_d;
    logic [2:0]        row_q, row_d;
    logic [2:0]        col_q, col_d;
    logic [6:0]        rd_cnt_q, rd_cnt_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;

    // Stage 1: address on the bus. Stage 2: data on rdata.
    logic              s1_vld_q;
    logic [1:0]        s1_bank_q;
    pix_t              s1_pix_q;
    logic              s2_vld_q;
    logic [1:0]        s2_bank_q;
    pix_t              s2_pix_q;

    logic              issue;
    logic              slot_free;
    logic [2:0]        slots_used;
    logic [WORD_W-1:0] rdata_sel;

    logic              wb_valid;
    logic              wb_pop;
    logic [BEAT_W-1:0] wb_data;
    logic [PIX_W-1:0]  wb_pix_raw;
    pix_t              wb_pix;
    logic [1:0]        wb_lane;
    logic [1:0]        wb_count;
    logic              beat_acc;
    logic              last_beat;

    // A read may issue only if its word will find a free buffer slot on
    // return: buffered words plus reads in flight, less a word retiring now.
    assign slots_used = {1'b0, wb_count} + {2'b00, s1_vld_q} + {2'b00, s2_vld_q};
    assign slot_free  = (slots_used - {2'b00, wb_pop}) < 3'd2;

    assign wb_pix    = pix_t'(wb_pix_raw);
    assign beat_acc  = wb_valid & out_ready_i;
    assign last_beat = wb_valid & (wb_pix == LAST_PIX) & (wb_lane == 2'd3);

    // Scan FSM next-state and read issue decision.
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    issue   = 1'b1;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                if (slot_free) begin
                    issue = 1'b1;
                    if (rd_cnt_q == 7'(NUM_READS - 1)) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (beat_acc && last_beat) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Scan counters: column innermost, then row, then group quad.
    always_comb begin
        gq_d     = gq_q;
        row_d    = row_q;
        col_d    = col_q;
        rd_cnt_d = rd_cnt_q;
        raddr_d  = raddr_q;
        if (issue) begin
            raddr_d  = map_addr(gq_q, row_q, col_q);
            rd_cnt_d = rd_cnt_q + 7'd1;
            if (col_q == 3'(MAP_DIM - 1)) begin
                col_d = 3'd0;
                if (row_q == 3'(MAP_DIM - 1)) begin
                    row_d = 3'd0;
                    gq_d  = gq_q + 2'd1;
                end else begin
                    row_d = row_q + 3'd1;
                end
            end else begin
                col_d = col_q + 3'd1;
            end
        end
        if (state_q == StDone) begin
            gq_d     = 2'd0;
            row_d    = 3'd0;
            col_d    = 3'd0;
            rd_cnt_d = 7'd0;
        end
    end

    // FSM, counters, address register and read-return pipeline.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            gq_q      <= 2'd0;
            row_q     <= 3'd0;
            col_q     <= 3'd0;
            rd_cnt_q  <= 7'd0;
            raddr_q   <= '0;
            s1_vld_q  <= 1'b0;
            s1_bank_q <= 2'd0;
            s1_pix_q  <= '0;
            s2_vld_q  <= 1'b0;
            s2_bank_q <= 2'd0;
            s2_pix_q  <= '0;
        end else begin
            state_q   <= state_d;
            gq_q      <= gq_d;
            row_q     <= row_d;
            col_q     <= col_d;
            rd_cnt_q  <= rd_cnt_d;
            raddr_q   <= raddr_d;
            s1_vld_q  <= issue;
            s1_bank_q <= map_bank(row_q, col_q);
            s1_pix_q  <= '{gq: gq_q, row: row_q, col: col_q};
            s2_vld_q  <= s1_vld_q;
            s2_bank_q <= s1_bank_q;
            s2_pix_q  <= s1_pix_q;
        end
    end

    // Pick the returning word from the bank the request was sent to.
    always_comb begin
        rdata_sel = sram_rdata_a0_i;
        unique case (s2_bank_q)
            2'd0: rdata_sel = sram_rdata_a0_i;
            2'd1: rdata_sel = sram_rdata_a1_i;
            2'd2: rdata_sel = sram_rdata_a2_i;
            2'd3: rdata_sel = sram_rdata_a3_i;
        endcase
    end

    act_reader_wbuf u_wbuf (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .wr_en_i    (s2_vld_q),
        .wr_word_i  (rdata_sel),
        .wr_pix_i   (s2_pix_q),
        .rd_ready_i (out_ready_i),
        .rd_valid_o (wb_valid),
        .rd_data_o  (wb_data),
        .rd_pix_o   (wb_pix_raw),
        .rd_lane_o  (wb_lane),
        .rd_pop_o   (wb_pop),
        .count_o    (wb_count)
    );

    assign sram_raddr_a0_o = raddr_q;
    assign sram_raddr_a1_o = raddr_q;
    assign sram_raddr_a2_o = raddr_q;
    assign sram_raddr_a3_o = raddr_q;

    assign busy_o      = (state_q == StFetch) || (state_q == StDrain);
    assign done_o      = (state_q == StDone);
    assign out_valid_o = wb_valid;
    assign out_data_o  = wb_data;
    assign out_grp_o   = {wb_pix.gq, wb_lane};
    assign out_row_o   = wb_pix.row;
    assign out_col_o   = wb_pix.col;
    assign out_last_o  = last_beat;

`ifdef ACT_READER_PERF_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Backpressure cycles seen during a scan, saturating.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == StIdle) && start_i) begin
            stall_cnt_d = 16'd0;
        end else if (wb_valid && !out_ready_i && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_act_a_reader.sv
// Bench for act_a_reader: SRAM bank model, queue-based beat model built from
// the scan order and address map, and a per-cycle compare process.
module tb_act_a_reader;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  grp;
        logic [2:0]  row;
        logic [2:0]  col;
        logic        last;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         busy, done;
    logic [5:0]   raddr0, raddr1, raddr2, raddr3;
    logic [127:0] rdata0, rdata1, rdata2, rdata3;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [31:0]  out_data;
    logic [3:0]   out_grp;
    logic [2:0]   out_row, out_col;
    logic         out_last;
`ifdef ACT_READER_PERF_EN
    logic [15:0]  stall_cnt;
`endif

    logic [127:0] mem [4][64];
    beat_t        exp_q[$];

    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    int  start_cyc = 0;
    int  last_acc_cyc = -100;
    int  first_cyc = 0;
    int  beats_acc = 0;
    int  done_cnt = 0;
    int  mode = 0;
    int  stall_ctr = 0;
    bit  stall_done = 1'b0;
    bit  active = 1'b0;
    bit  rst_smp = 1'b0;
    bit  prev_stall = 1'b0;
    logic [43:0] prev_payload;
    logic [31:0] first_data, last_data;
    logic [31:0] cap [4];

    act_a_reader dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .start_i         (start),
        .busy_o          (busy),
        .done_o          (done),
        .sram_raddr_a0_o (raddr0),
        .sram_raddr_a1_o (raddr1),
        .sram_raddr_a2_o (raddr2),
        .sram_raddr_a3_o (raddr3),
        .sram_rdata_a0_i (rdata0),
        .sram_rdata_a1_i (rdata1),
        .sram_rdata_a2_i (rdata2),
        .sram_rdata_a3_i (rdata3),
        .out_valid_o     (out_valid),
        .out_ready_i     (out_ready),
        .out_data_o      (out_data),
        .out_grp_o       (out_grp),
        .out_row_o       (out_row),
        .out_col_o       (out_col),
        .out_last_o      (out_last)
`ifdef ACT_READER_PERF_EN
        ,
        .stall_cnt_o     (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rst_smp <= rst;
        rdata0  <= mem[0][raddr0];
        rdata1  <= mem[1][raddr1];
        rdata2  <= mem[2][raddr2];
        rdata3  <= mem[3][raddr3];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h at cyc %0d", name, act, exp, cyc);
        end
    endtask

    // Expected beat stream straight from the scan order and the address map.
    task automatic build_expected();
        logic [127:0] w;
        beat_t e;
        int bank, addr;
        exp_q.delete();
        for (int gq = 0; gq < 4; gq++)
            for (int r = 0; r < 5; r++)
                for (int c = 0; c < 5; c++)
                    for (int l = 0; l < 4; l++) begin
                        bank   = (r % 2) * 2 + (c % 2);
                        addr   = 18 * (gq / 2) + 3 * (gq % 2) + 6 * (r / 2) + c / 2;
                        w      = mem[bank][addr];
                        e.data = w[127 - 32 * l -: 32];
                        e.grp  = 4'(4 * gq + l);
                        e.row  = 3'(r);
                        e.col  = 3'(c);
                        e.last = (gq == 3 && r == 4 && c == 4 && l == 3);
                        exp_q.push_back(e);
                    end
    endtask

    // Consumer ready pattern: 0 always ready, 1 random, 2 ten-cycle stall at beat 3.
    always @(posedge clk) begin
        #1;
        case (mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            default: begin
                if (beats_acc == 3 && !stall_done) begin
                    out_ready = 1'b0;
                    stall_ctr++;
                    if (stall_ctr == 10) stall_done = 1'b1;
                end else begin
                    out_ready = 1'b1;
                end
            end
        endcase
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        logic [43:0] payload;
        beat_t e;
        payload = {out_valid, out_data, out_grp, out_row, out_col, out_last};
        if (rst_smp) begin
            check("rst_outputs", 64'({out_valid, busy, done, out_last, out_data, out_grp,
                                      out_row, out_col}), 64'd0);
            check("rst_raddr", 64'({raddr0, raddr1, raddr2, raddr3}), 64'd0);
            exp_q.delete();
            active     = 1'b0;
            prev_stall = 1'b0;
        end else begin
            check("busy", 64'(busy), 64'(active));
            check("done", 64'(done), 64'(cyc == last_acc_cyc + 1));
            if (done) done_cnt++;
            check("raddr_equal", 64'(raddr1 == raddr0 && raddr2 == raddr0 && raddr3 == raddr0),
                  64'd1);
            if (prev_stall) check("hold_while_stalled", 64'(payload), 64'(prev_payload));
            if (mode != 1 && active && cyc >= start_cyc + 2)
                check("no_bubble", 64'(out_valid), 64'd1);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat: actual=%0h required=no beat at cyc %0d",
                             payload, cyc);
                end else begin
                    check("beat", 64'({out_data, out_grp, out_row, out_col, out_last}),
                          64'(exp_q[0]));
                    if (out_ready) begin
                        e = exp_q.pop_front();
                        beats_acc++;
                        if (beats_acc == 1) begin
                            first_cyc  = cyc;
                            first_data = out_data;
                        end
                        if (out_row == 3'd3 && out_col == 3'd4 && out_grp >= 4'd4 &&
                            out_grp <= 4'd7)
                            cap[out_grp[1:0]] = out_data;
                        if (e.last) begin
                            last_acc_cyc = cyc;
                            last_data    = out_data;
                            active       = 1'b0;
                        end
                    end
                end
            end
            prev_stall   = out_valid && !out_ready;
            prev_payload = payload;
        end
    end

    task automatic do_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        start_cyc  = cyc;
        build_expected();
        active     = 1'b1;
        beats_acc  = 0;
        done_cnt   = 0;
        stall_ctr  = 0;
        stall_done = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 3000 && active; i++) begin
            @(posedge clk);
            #1;
        end
        if (active) begin
            checks++;
            failures++;
            $display("FAIL scan_timeout: actual=%0d beats required=400", beats_acc);
            active = 1'b0;
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start_at(input int c);
        for (int i = 0; i < 5000 && cyc < c; i++) begin
            @(posedge clk);
            #1;
        end
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    initial begin
        logic [127:0] w;
        for (int b = 0; b < 4; b++)
            for (int a = 0; a < 64; a++) begin
                for (int l = 0; l < 4; l++) w[127 - 32 * l -: 32] = {8'(b), 8'(a), 8'(l), 8'h5A};
                mem[b][a] = w;
            end
        mem[2][11] = 128'h00112233_44556677_8899AABB_CCDDEEFF;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Full scan at full speed.
        mode = 0;
        do_start();
        wait_done();
        check("first_beat_cycle", 64'(first_cyc - start_cyc), 64'd2);
        check("last_beat_cycle", 64'(last_acc_cyc - start_cyc), 64'd401);
        check("done_pulses", 64'(done_cnt), 64'd1);
        check("beats_left", 64'(exp_q.size()), 64'd0);
        check("first_beat_data", 64'(first_data), 64'h0000005A);
        check("last_beat_data", 64'(last_data), 64'h0023035A);
        check("b2a11_lane0", 64'(cap[0]), 64'h00112233);
        check("b2a11_lane1", 64'(cap[1]), 64'h44556677);
        check("b2a11_lane2", 64'(cap[2]), 64'h8899AABB);
        check("b2a11_lane3", 64'(cap[3]), 64'hCCDDEEFF);
`ifdef ACT_READER_PERF_EN
        check("stall_cnt_full_speed", 64'(stall_cnt), 64'd0);
`endif

        // Random backpressure.
        mode = 1;
        do_start();
        wait_done();
        check("rand_done_pulses", 64'(done_cnt), 64'd1);
        check("rand_beats_left", 64'(exp_q.size()), 64'd0);

        // Ten-cycle stall on the last lane of the first word.
        mode = 2;
        do_start();
        wait_done();
        check("stall_last_beat_cycle", 64'(last_acc_cyc - start_cyc), 64'd411);
        check("stall_done_pulses", 64'(done_cnt), 64'd1);
        check("stall_beats_left", 64'(exp_q.size()), 64'd0);
`ifdef ACT_READER_PERF_EN
        check("stall_cnt", 64'(stall_cnt), 64'd10);
`endif

        // Reset mid-scan, then a fresh scan from the origin.
        mode = 0;
        do_start();
        for (int i = 0; i < 1000 && beats_acc < 150; i++) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_start();
        wait_done();
        check("restart_first_cycle", 64'(first_cyc - start_cyc), 64'd2);
        check("restart_first_data", 64'(first_data), 64'h0000005A);
        check("restart_done_pulses", 64'(done_cnt), 64'd1);
        check("restart_beats_left", 64'(exp_q.size()), 64'd0);

        // start while busy and start during DONE are both ignored.
        do_start();
        pulse_start_at(start_cyc + 50);
        pulse_start_at(start_cyc + 402);
        wait_done();
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        check("busy_start_done_pulses", 64'(done_cnt), 64'd1);
        check("busy_start_last_cycle", 64'(last_acc_cyc - start_cyc), 64'd401);
        check("busy_start_beats_left", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
